gerenciador_carga: RTL and testbench

Load manager between the greenhouse request sources (light and irrigation timers, humidity and temperature hysteresis controllers) and the physical actuator drivers. It limits how many loads run at once to a fixed power budget and grants free slots round-robin. Each load gets a minimum on-time and a post-release cooldown. Request lines arrive as levels; the block drives the registered enable for each actuator.

---
 rtl/gerenciador_carga_pkg.sv | 19 +
 rtl/gerenciador_carga_canal.sv | 79 +++++++
 rtl/gerenciador_carga.sv | 95 +++++++++
 tb/tb_gerenciador_carga.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/gerenciador_carga_pkg.sv
// Shared definitions for the greenhouse load manager: channel state
// encoding, default timing limits and channel index names.
package gerenciador_pkg;

  typedef enum logic [1:0] {
    DESL = 2'd0,
    LIG  = 2'd1,
    RESF = 2'd2
  } estado_t;

  localparam int unsigned MIN_LIG_PADRAO  = 8;
  localparam int unsigned MIN_DESL_PADRAO = 4;

  localparam int unsigned CH_LUZ   = 0;
  localparam int unsigned CH_IRRIG = 1;
  localparam int unsigned CH_UMID  = 2;
  localparam int unsigned CH_TEMP  = 3;

endpackage

// File: rtl/gerenciador_carga_canal.sv
// One load channel: DESL/LIG/RESF state machine with a per-state counter
// that clears on every state entry and saturates at the state's limit.
module canal_carga
  import gerenciador_pkg::*;
#(
  parameter int unsigned MIN_LIG  = MIN_LIG_PADRAO,
  parameter int unsigned MIN_DESL = MIN_DESL_PADRAO,
  parameter int unsigned CNT_W    = 5
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    grant,
  input  logic    req,
  input  logic    en_global,
  output estado_t estado,
  output logic    lig,
  output logic    libera
);

  localparam logic [CNT_W-1:0] LIM_LIG  = CNT_W'(MIN_LIG - 1);
  localparam logic [CNT_W-1:0] LIM_DESL = CNT_W'(MIN_DESL - 1);

  estado_t          estado_q, estado_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lig_q;

  // Next state and counter; libera flags a LIG exit happening at this edge.
  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    libera   = 1'b0;
    unique case (estado_q)
      DESL: begin
        if (grant && req && en_global) begin
          estado_d = LIG;
          cnt_d    = '0;
        end
      end
      LIG: begin
        if (!en_global || (!req && (cnt_q >= LIM_LIG))) begin
          estado_d = RESF;
          cnt_d    = '0;
          libera   = 1'b1;
        end else if (cnt_q < LIM_LIG) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESF: begin
        if (cnt_q >= LIM_DESL) begin
          estado_d = DESL;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        estado_d = DESL;
        cnt_d    = '0;
      end
    endcase
  end

  // State, counter and registered actuator enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= DESL;
      cnt_q    <= '0;
      lig_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      lig_q    <= (estado_d == LIG);
    end
  end

  assign estado = estado_q;
  assign lig    = lig_q;

endmodule

// File: rtl/gerenciador_carga.sv
// Load manager: caps simultaneously enabled loads at MAX_ATIVOS and hands
// free slots to requesting idle channels in round-robin order.
module gerenciador_carga
  import gerenciador_pkg::*;
#(
  parameter int unsigned N_CANAIS   = 4,
  parameter int unsigned MAX_ATIVOS = 2,
  parameter int unsigned MIN_LIG    = MIN_LIG_PADRAO,
  parameter int unsigned MIN_DESL   = MIN_DESL_PADRAO,
  parameter int unsigned CNT_W      = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en_global,
  input  logic [N_CANAIS-1:0]               req,
  output logic [N_CANAIS-1:0]               lig,
  output logic [N_CANAIS-1:0]               pendente,
  output logic [$clog2(N_CANAIS+1)-1:0]     ativos
);

  localparam int unsigned ATV_W = $clog2(N_CANAIS + 1);
  localparam int unsigned PTR_W = (N_CANAIS > 1) ? $clog2(N_CANAIS) : 1;

  estado_t             estado_w [N_CANAIS];
  logic [N_CANAIS-1:0] lig_w, libera_w, grant, cand;
  logic [N_CANAIS-1:0] pendente_q, pendente_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d, idx, ultimo;
  logic [ATV_W-1:0]    ativos_q, ativos_d;
  int unsigned         livre, n_conc, n_lib;

  for (genvar g = 0; g < N_CANAIS; g++) begin : g_canal
    canal_carga #(
      .MIN_LIG  (MIN_LIG),
      .MIN_DESL (MIN_DESL),
      .CNT_W    (CNT_W)
    ) u_canal (
      .clk       (clk),
      .rst_n     (rst_n),
      .grant     (grant[g]),
      .req       (req[g]),
      .en_global (en_global),
      .estado    (estado_w[g]),
      .lig       (lig_w[g]),
      .libera    (libera_w[g])
    );
  end

  // Round-robin grant of free slots from ptr; releases this cycle still
  // occupy their slot because ativos_q only drops at the edge.
  always_comb begin
    grant  = '0;
    cand   = '0;
    ptr_d  = ptr_q;
    idx    = '0;
    ultimo = '0;
    n_conc = 0;
    n_lib  = 0;
    livre  = (MAX_ATIVOS > 32'(ativos_q)) ? (MAX_ATIVOS - 32'(ativos_q)) : 0;
    for (int unsigned i = 0; i < N_CANAIS; i++) begin
      cand[i] = en_global & req[i] & (estado_w[i] == DESL);
      n_lib   = n_lib + 32'(libera_w[i]);
    end
    for (int unsigned k = 0; k < N_CANAIS; k++) begin
      idx = PTR_W'((32'(ptr_q) + k) % N_CANAIS);
      if (cand[idx] && (n_conc < livre)) begin
        grant[idx] = 1'b1;
        n_conc     = n_conc + 1;
        ultimo     = idx;
      end
    end
    if (n_conc != 0) begin
      ptr_d = PTR_W'((32'(ultimo) + 1) % N_CANAIS);
    end
    ativos_d   = ATV_W'(32'(ativos_q) + n_conc - n_lib);
    pendente_d = cand & ~grant;
  end

  // Arbiter pointer, active-load count and pending flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= '0;
      ativos_q   <= '0;
      pendente_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      ativos_q   <= ativos_d;
      pendente_q <= pendente_d;
    end
  end

  assign lig      = lig_w;
  assign pendente = pendente_q;
  assign ativos   = ativos_q;

endmodule

// File: tb/tb_gerenciador_carga.sv
// Scoreboard bench for gerenciador_carga with default parameters.
// The driver pushes hand-computed expectations tagged with the cycle they
// apply to; a monitor pops and compares them on the falling edge.
module tb_gerenciador_carga;
  import gerenciador_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_global = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] lig, pendente;
  logic [2:0] ativos;

  typedef struct {
    int         ciclo;
    logic [3:0] lig;
    logic [3:0] pend;
    logic [2:0] ativ;
    string      nome;
  } esp_t;

  esp_t fila[$];
  int   ciclo = 0;
  int   n_comp = 0;
  int   n_falha = 0;
  event amostra_ev;

  gerenciador_carga #(
    .N_CANAIS   (4),
    .MAX_ATIVOS (2),
    .MIN_LIG    (MIN_LIG_PADRAO),
    .MIN_DESL   (MIN_DESL_PADRAO),
    .CNT_W      (5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_global (en_global),
    .req       (req),
    .lig       (lig),
    .pendente  (pendente),
    .ativos    (ativos)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ciclo <= ciclo + 1;

  task automatic compara(input string nome, input int atual, input int esperado);
    n_comp++;
    if (atual != esperado) begin
      n_falha++;
      $display("FAIL %s (ciclo %0d): obtido=%0h esperado=%0h", nome, ciclo, atual, esperado);
    end
  endtask

  // Monitor: pops every expectation due by now and checks the invariants.
  initial begin
    esp_t e;
    forever begin
      @(negedge clk or amostra_ev);
      while (fila.size() > 0 && fila[0].ciclo <= ciclo) begin
        e = fila.pop_front();
        compara({e.nome, ".lig"}, int'(lig), int'(e.lig));
        compara({e.nome, ".pendente"}, int'(pendente), int'(e.pend));
        compara({e.nome, ".ativos"}, int'(ativos), int'(e.ativ));
      end
      compara("inv_max_ativos", (ativos <= 3'd2) ? 1 : 0, 1);
      compara("inv_contagem", int'(ativos), $countones(lig));
    end
  end

  task automatic passo(input logic [3:0] r, input logic en, input logic [3:0] el,
                       input logic [3:0] ep, input logic [2:0] ea, input string nome);
    esp_t e;
    req       = r;
    en_global = en;
    e.ciclo = ciclo + 1;
    e.lig   = el;
    e.pend  = ep;
    e.ativ  = ea;
    e.nome  = nome;
    fila.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic repete(input int n, input logic [3:0] r, input logic en, input logic [3:0] el,
                        input logic [3:0] ep, input logic [2:0] ea, input string nome);
    for (int i = 0; i < n; i++) passo(r, en, el, ep, ea, nome);
  endtask

  // Asserts reset between edges and checks outputs are cleared before any edge.
  task automatic pulso_reset(input string nome);
    esp_t e;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    e.ciclo = ciclo;
    e.lig   = '0;
    e.pend  = '0;
    e.ativ  = '0;
    e.nome  = nome;
    fila.push_back(e);
    ->amostra_ev;
    #1;
    req       = '0;
    en_global = 1'b1;
    rst_n     = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulacao excedeu o limite de tempo");
    $fatal(1, "watchdog");
  end

  initial begin
    pulso_reset("reset_inicial");

    // Single short request: 8-cycle minimum on, 5 cycles off before re-grant.
    repete(3, 4'b0001, 1, 4'b0001, 4'b0000, 3'd1, "A_lig");
    repete(5, 4'b0000, 1, 4'b0001, 4'b0000, 3'd1, "A_min");
    passo(4'b0000, 1, 4'b0000, 4'b0000, 3'd0, "A_solta");
    repete(4, 4'b0001, 1, 4'b0000, 4'b0000, 3'd0, "A_resf");
    passo(4'b0001, 1, 4'b0001, 4'b0000, 3'd1, "A_regrant");
    pulso_reset("A_reset");

    // Contention, then fairness between pairs {0,1} and {2,3}.
    passo(4'b1111, 1, 4'b0011, 4'b1100, 3'd2, "B_conc");
    repete(7, 4'b1111, 1, 4'b0011, 4'b1100, 3'd2, "B_mant");
    passo(4'b1100, 1, 4'b0000, 4'b1100, 3'd0, "B_solta");
    passo(4'b1100, 1, 4'b1100, 4'b0000, 3'd2, "B_vez23");
    repete(3, 4'b1111, 1, 4'b1100, 4'b0000, 3'd2, "C_resf01");
    repete(4, 4'b1111, 1, 4'b1100, 4'b0011, 3'd2, "C_espera01");
    passo(4'b0011, 1, 4'b0000, 4'b0011, 3'd0, "C_solta23");
    passo(4'b0011, 1, 4'b0011, 4'b0000, 3'd2, "C_vez01");
    repete(3, 4'b1111, 1, 4'b0011, 4'b0000, 3'd2, "C_resf23");
    passo(4'b1111, 1, 4'b0011, 4'b1100, 3'd2, "C_espera23");
    pulso_reset("C_reset");

    // Safety override during minimum on-time, then resume from ptr=2.
    passo(4'b0011, 1, 4'b0011, 4'b0000, 3'd2, "D_liga");
    repete(2, 4'b0011, 1, 4'b0011, 4'b0000, 3'd2, "D_min");
    passo(4'b1111, 0, 4'b0000, 4'b0000, 3'd0, "D_corta");
    repete(4, 4'b1111, 0, 4'b0000, 4'b0000, 3'd0, "D_bloq");
    passo(4'b1111, 1, 4'b1100, 4'b0011, 3'd2, "D_volta");
    pulso_reset("D_reset");

    // Request toggling during cooldown is ignored.
    passo(4'b0100, 1, 4'b0100, 4'b0000, 3'd1, "E_liga");
    repete(7, 4'b0100, 1, 4'b0100, 4'b0000, 3'd1, "E_min");
    passo(4'b0000, 1, 4'b0000, 4'b0000, 3'd0, "E_solta");
    passo(4'b0100, 1, 4'b0000, 4'b0000, 3'd0, "E_resf");
    passo(4'b0000, 1, 4'b0000, 4'b0000, 3'd0, "E_resf");
    repete(2, 4'b0100, 1, 4'b0000, 4'b0000, 3'd0, "E_resf");
    passo(4'b0100, 1, 4'b0100, 4'b0000, 3'd1, "E_fim");
    pulso_reset("E_reset");

    // Asynchronous reset mid-operation, immediate re-grant afterwards.
    repete(2, 4'b0111, 1, 4'b0011, 4'b0100, 3'd2, "F_liga");
    pulso_reset("F_rst_async");
    passo(4'b0001, 1, 4'b0001, 4'b0000, 3'd1, "F_pos_rst");

    @(negedge clk);
    #1;
    if (fila.size() != 0) begin
      n_comp++;
      n_falha++;
      $display("FAIL fila_pendente: obtido=%0d esperado=0", fila.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_falha);
    $finish;
  end

endmodule
